// File: rtl/jedro_1_defines.sv
// ----------------------------------------------------------------------------
// jedro_1_defines
// Shared constants and types for the jedro_1 data-side arbiter.
//   XLEN        : data/address width of the data bus
//   NBYTES      : byte-strobe width (XLEN/8)
//   arb_port_e  : requester identity (LSU = port 0, AUX = port 1)
//   arb_state_e : arbiter grant FSM states
// ----------------------------------------------------------------------------
package jedro_1_defines;

    localparam int XLEN   = 32;
    localparam int NBYTES = XLEN / 8;

    typedef enum logic {
        ePORT_LSU = 1'b0,
        ePORT_AUX = 1'b1
    } arb_port_e;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eHOLD0 = 2'd1,
        eHOLD1 = 2'd2
    } arb_state_e;

endpackage : jedro_1_defines

// File: rtl/jedro_1_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// jedro_1_arb_id_fifo
// Small FIFO of requester IDs, one entry per accepted-but-unanswered request.
// Responses come back in order, so the head entry names the port that owns
// the next response.
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset (empties the FIFO)
//   push_i  in   enqueue din_i (ignored while full, even if popping)
//   din_i   in   port ID to enqueue
//   pop_i   in   dequeue head (ignored while empty)
//   head_o  out  port ID at the head
//   full_o  out  DEPTH entries held
//   empty_o out  no entries held
// ----------------------------------------------------------------------------
module jedro_1_arb_id_fifo
    import jedro_1_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  arb_port_e din_i,
    input  logic      pop_i,
    output arb_port_e head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_port_e       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);

    // Push is gated on the current full flag only, so a pop in the same
    // cycle does not make room until the next cycle.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    assign head_o = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : jedro_1_arb_id_fifo

// File: rtl/jedro_1_data_arbiter.sv
// ----------------------------------------------------------------------------
// jedro_1_data_arbiter
// Shares one data-bus request/response port between the LSU (port 0) and an
// auxiliary master (port 1). One request is granted at a time; a grant that
// stalls on the bus is frozen until it is accepted. The ID of every accepted
// request is queued so in-order responses can be routed back to their owner.
//
// Build option:
//   JEDRO_1_DATA_ARB_RR_EN  defined   -> round-robin arbitration
//                           undefined -> fixed priority, port 0 always wins
//
// Ports (N = 0,1):
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mN_req_*_i / _ready_o  requester N request channel
//   mN_rsp_*_o             requester N response channel (always accepted)
//   data_req_*             forwarded bus request
//   data_rsp_*             bus response (data_rsp_ready_o tied to 1)
//   spurious_rsp_o         response seen with no outstanding request
// ----------------------------------------------------------------------------
module jedro_1_data_arbiter
    import jedro_1_defines::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [XLEN-1:0]   m0_req_addr_i,
    input  logic [XLEN-1:0]   m0_req_data_i,
    input  logic [NBYTES-1:0] m0_req_strobe_i,
    input  logic              m0_req_write_i,
    input  logic              m0_req_valid_i,
    output logic              m0_req_ready_o,
    output logic [XLEN-1:0]   m0_rsp_data_o,
    output logic              m0_rsp_error_o,
    output logic              m0_rsp_valid_o,

    input  logic [XLEN-1:0]   m1_req_addr_i,
    input  logic [XLEN-1:0]   m1_req_data_i,
    input  logic [NBYTES-1:0] m1_req_strobe_i,
    input  logic              m1_req_write_i,
    input  logic              m1_req_valid_i,
    output logic              m1_req_ready_o,
    output logic [XLEN-1:0]   m1_rsp_data_o,
    output logic              m1_rsp_error_o,
    output logic              m1_rsp_valid_o,

    output logic [XLEN-1:0]   data_req_addr_o,
    output logic [XLEN-1:0]   data_req_data_o,
    output logic [NBYTES-1:0] data_req_strobe_o,
    output logic              data_req_write_o,
    output logic              data_req_valid_o,
    input  logic              data_req_ready_i,
    input  logic [XLEN-1:0]   data_rsp_data_i,
    input  logic              data_rsp_error_i,
    input  logic              data_rsp_valid_i,
    output logic              data_rsp_ready_o,

    output logic              spurious_rsp_o
);

    arb_state_e  r_state;
    arb_port_e   w_gnt;
    logic        w_gnt_valid;
    logic        w_fire;
    logic        w_full;
    logic        w_empty;
    arb_port_e   w_head;
    logic [1:0]  w_req_ready;
    logic [1:0]  w_rsp_valid;

`ifdef JEDRO_1_DATA_ARB_RR_EN
    arb_port_e   r_rr_ptr;
`endif

    // ------------------------------------------------------------------
    // Grant selection. In a HOLD state the grant is frozen to the stalled
    // port; the other port's valid has no influence until the fire.
    // With nobody valid the grant rests on the preferred port.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt = ePORT_LSU;
        case (r_state)
            eHOLD0: w_gnt = ePORT_LSU;
            eHOLD1: w_gnt = ePORT_AUX;
            default: begin
`ifdef JEDRO_1_DATA_ARB_RR_EN
                if (r_rr_ptr == ePORT_AUX) begin
                    w_gnt = (m1_req_valid_i | ~m0_req_valid_i) ? ePORT_AUX : ePORT_LSU;
                end else begin
                    w_gnt = (m0_req_valid_i | ~m1_req_valid_i) ? ePORT_LSU : ePORT_AUX;
                end
`else
                w_gnt = (m0_req_valid_i | ~m1_req_valid_i) ? ePORT_LSU : ePORT_AUX;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request path: pure mux from the granted port, no added latency.
    // ------------------------------------------------------------------
    assign w_gnt_valid       = (w_gnt == ePORT_AUX) ? m1_req_valid_i  : m0_req_valid_i;
    assign data_req_addr_o   = (w_gnt == ePORT_AUX) ? m1_req_addr_i   : m0_req_addr_i;
    assign data_req_data_o   = (w_gnt == ePORT_AUX) ? m1_req_data_i   : m0_req_data_i;
    assign data_req_strobe_o = (w_gnt == ePORT_AUX) ? m1_req_strobe_i : m0_req_strobe_i;
    assign data_req_write_o  = (w_gnt == ePORT_AUX) ? m1_req_write_i  : m0_req_write_i;

    // Nothing is forwarded while the ID FIFO cannot record another request.
    assign data_req_valid_o  = w_gnt_valid & ~w_full;
    assign w_fire            = data_req_valid_o & data_req_ready_i;

    // Per-port ready and response-valid decode.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign w_req_ready[gi] = (w_gnt == arb_port_e'(1'(gi))) & data_req_ready_i & ~w_full;
        assign w_rsp_valid[gi] = data_rsp_valid_i & ~w_empty & (w_head == arb_port_e'(1'(gi)));
    end

    assign m0_req_ready_o = w_req_ready[0];
    assign m1_req_ready_o = w_req_ready[1];

    // ------------------------------------------------------------------
    // Response path: routed by the oldest outstanding ID.
    // ------------------------------------------------------------------
    assign m0_rsp_valid_o   = w_rsp_valid[0];
    assign m1_rsp_valid_o   = w_rsp_valid[1];
    assign m0_rsp_data_o    = data_rsp_data_i;
    assign m1_rsp_data_o    = data_rsp_data_i;
    assign m0_rsp_error_o   = data_rsp_error_i;
    assign m1_rsp_error_o   = data_rsp_error_i;
    assign data_rsp_ready_o = 1'b1;
    assign spurious_rsp_o   = data_rsp_valid_i & w_empty;

    jedro_1_arb_id_fifo #(
        .DEPTH   (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_fire),
        .din_i   (w_gnt),
        .pop_i   (data_rsp_valid_i),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // ------------------------------------------------------------------
    // Grant FSM. A stall (valid, FIFO has room, bus not ready) locks the
    // grant; a FIFO-full stall does not lock, the state is simply kept.
    // A requester dropping valid in HOLD leaves the FSM in HOLD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= eIDLE;
        end else begin
            case (r_state)
                eIDLE: begin
                    if (w_gnt_valid && !w_full && !data_req_ready_i) begin
                        r_state <= (w_gnt == ePORT_AUX) ? eHOLD1 : eHOLD0;
                    end
                end
                eHOLD0, eHOLD1: begin
                    if (w_fire) begin
                        r_state <= eIDLE;
                    end
                end
                default: r_state <= eIDLE;
            endcase
        end
    end

`ifdef JEDRO_1_DATA_ARB_RR_EN
    // After each fire the other port becomes the preferred one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= ePORT_LSU;
        end else if (w_fire) begin
            r_rr_ptr <= (w_gnt == ePORT_LSU) ? ePORT_AUX : ePORT_LSU;
        end
    end
`endif

endmodule : jedro_1_data_arbiter

// File: tb/tb_jedro_1_data_arbiter.sv
// ----------------------------------------------------------------------------
// tb_jedro_1_data_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level model (queue of outstanding owners, lock/preference ints).
// ----------------------------------------------------------------------------
module tb_jedro_1_data_arbiter;

    localparam int MAX_OUTST = 4;
`ifdef JEDRO_1_DATA_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;

    logic [31:0] req_addr  [2];
    logic [31:0] req_data  [2];
    logic [3:0]  req_strb  [2];
    logic        req_write [2];
    logic        req_valid [2];

    logic        m0_req_ready_o, m1_req_ready_o;
    logic [31:0] m0_rsp_data_o, m1_rsp_data_o;
    logic        m0_rsp_error_o, m1_rsp_error_o;
    logic        m0_rsp_valid_o, m1_rsp_valid_o;

    logic [31:0] data_req_addr_o, data_req_data_o;
    logic [3:0]  data_req_strobe_o;
    logic        data_req_write_o, data_req_valid_o;
    logic        bus_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_valid;
    logic        data_rsp_ready_o;
    logic        spurious_rsp_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int q[$];          // owners of accepted, unanswered requests (oldest first)
    int lock   = -1;   // port whose stalled request is frozen, -1 if none
    int rr     = 0;    // preferred port when both request (round-robin build)
    bit last_fire;
    int last_gnt;
    int fired[$];

    always #5 clk = ~clk;

    jedro_1_data_arbiter #(
        .MAX_OUTST         (MAX_OUTST)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .m0_req_addr_i     (req_addr[0]),
        .m0_req_data_i     (req_data[0]),
        .m0_req_strobe_i   (req_strb[0]),
        .m0_req_write_i    (req_write[0]),
        .m0_req_valid_i    (req_valid[0]),
        .m0_req_ready_o    (m0_req_ready_o),
        .m0_rsp_data_o     (m0_rsp_data_o),
        .m0_rsp_error_o    (m0_rsp_error_o),
        .m0_rsp_valid_o    (m0_rsp_valid_o),
        .m1_req_addr_i     (req_addr[1]),
        .m1_req_data_i     (req_data[1]),
        .m1_req_strobe_i   (req_strb[1]),
        .m1_req_write_i    (req_write[1]),
        .m1_req_valid_i    (req_valid[1]),
        .m1_req_ready_o    (m1_req_ready_o),
        .m1_rsp_data_o     (m1_rsp_data_o),
        .m1_rsp_error_o    (m1_rsp_error_o),
        .m1_rsp_valid_o    (m1_rsp_valid_o),
        .data_req_addr_o   (data_req_addr_o),
        .data_req_data_o   (data_req_data_o),
        .data_req_strobe_o (data_req_strobe_o),
        .data_req_write_o  (data_req_write_o),
        .data_req_valid_o  (data_req_valid_o),
        .data_req_ready_i  (bus_ready),
        .data_rsp_data_i   (rsp_data),
        .data_rsp_error_i  (rsp_err),
        .data_rsp_valid_i  (rsp_valid),
        .data_rsp_ready_o  (data_rsp_ready_o),
        .spurious_rsp_o    (spurious_rsp_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit v, input logic [31:0] a, input bit w);
        req_valid[p] = v;
        req_addr[p]  = a;
        req_data[p]  = $urandom;
        req_strb[p]  = 4'($urandom);
        req_write[p] = w;
    endtask

    // One clock: compare all outputs against the model, then advance it.
    // Entered at posedge+1 (inputs already driven), leaves at posedge+1.
    task automatic tick();
        int  g;
        int  head;
        bit  full, ev, fire, any;
        @(negedge clk);
        full = (q.size() == MAX_OUTST);
        any  = (lock >= 0) || req_valid[0] || req_valid[1];
        if (lock >= 0)                     g = lock;
        else if (req_valid[0] && req_valid[1]) g = RR_EN ? rr : 0;
        else if (req_valid[1])             g = 1;
        else                               g = 0;
        ev   = req_valid[g] && !full;
        fire = ev && bus_ready;

        chk("req_valid", data_req_valid_o, ev);
        if (any) begin
            chk("m0_req_ready", m0_req_ready_o, g == 0 && bus_ready && !full);
            chk("m1_req_ready", m1_req_ready_o, g == 1 && bus_ready && !full);
        end
        if (ev) begin
            chk("req_addr",   data_req_addr_o,   req_addr[g]);
            chk("req_data",   data_req_data_o,   req_data[g]);
            chk("req_strobe", data_req_strobe_o, req_strb[g]);
            chk("req_write",  data_req_write_o,  req_write[g]);
        end
        chk("rsp_ready", data_rsp_ready_o, 1);
        if (q.size() == 0) begin
            chk("spurious",     spurious_rsp_o, rsp_valid);
            chk("m0_rsp_valid", m0_rsp_valid_o, 0);
            chk("m1_rsp_valid", m1_rsp_valid_o, 0);
        end else begin
            head = q[0];
            chk("spurious",     spurious_rsp_o, 0);
            chk("m0_rsp_valid", m0_rsp_valid_o, rsp_valid && head == 0);
            chk("m1_rsp_valid", m1_rsp_valid_o, rsp_valid && head == 1);
            if (rsp_valid) begin
                chk("rsp_data",  (head == 0) ? m0_rsp_data_o  : m1_rsp_data_o,  rsp_data);
                chk("rsp_error", (head == 0) ? m0_rsp_error_o : m1_rsp_error_o, rsp_err);
            end
        end

        @(posedge clk);
        if (rsp_valid && q.size() > 0) void'(q.pop_front());
        if (fire) begin
            q.push_back(g);
            lock = -1;
            rr   = 1 - g;
        end else if (lock < 0 && ev && !bus_ready) begin
            lock = g;
        end
        last_fire = fire;
        last_gnt  = g;
        #1;
    endtask

    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = $urandom;
            rsp_err   = 1'($urandom);
            tick();
        end
        rsp_valid = 1'b0;
    endtask

    int exp_rr[4] = '{0, 1, 0, 1};
    int exp_fx[4] = '{0, 0, 0, 0};

    initial begin
        rst_i     = 1'b1;
        bus_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 32'h0, 1'b0);
        last_fire = 1'b0;
        last_gnt  = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid",    data_req_valid_o, 0);
        chk("rst_m0_ready",     m0_req_ready_o,   0);
        chk("rst_m1_ready",     m1_req_ready_o,   0);
        chk("rst_m0_rsp_valid", m0_rsp_valid_o,   0);
        chk("rst_m1_rsp_valid", m1_rsp_valid_o,   0);
        chk("rst_spurious",     spurious_rsp_o,   0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Both ports valid, bus always ready, four cycles
        bus_ready = 1'b1;
        set_req(0, 1'b1, 32'h200, 1'b0);
        set_req(1, 1'b1, 32'h300, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t2_m1_ready", m1_req_ready_o, RR_EN ? (i % 2 == 1) : 0);
            tick();
            if (last_fire) fired.push_back(last_gnt);
            for (int p = 0; p < 2; p++)
                if (last_fire && last_gnt == p) set_req(p, 1'b1, 32'h400 + 32'(i * 16 + p * 4), 1'b0);
        end
        for (int i = 0; i < 4; i++)
            chk("t2_grant", (i < fired.size()) ? fired[i] : -1, RR_EN ? exp_rr[i] : exp_fx[i]);
        set_req(0, 1'b0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 1'b0);
        respond(4);

        // Port 0 read of 0x100, answered the next cycle
        set_req(0, 1'b1, 32'h100, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        rsp_valid    = 1'b1;
        rsp_data     = 32'hDEADBEEF;
        rsp_err      = 1'b0;
        #2;
        chk("t1_m0_rsp_valid", m0_rsp_valid_o, 1);
        chk("t1_m0_rsp_data",  m0_rsp_data_o,  32'hDEADBEEF);
        chk("t1_m1_rsp_valid", m1_rsp_valid_o, 0);
        tick();
        rsp_valid = 1'b0;

        // Port 1 stalls on the bus; port 0 arrives during the stall
        bus_ready = 1'b0;
        set_req(1, 1'b1, 32'hA1A1_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t3_hold_addr", data_req_addr_o, 32'hA1A1_0000);
            tick();
        end
        set_req(0, 1'b1, 32'hA0A0_0000, 1'b0);
        #2;
        chk("t3_hold_vs_p0", data_req_addr_o, 32'hA1A1_0000);
        tick();
        bus_ready = 1'b1;
        #2;
        chk("t3_fire_p1", m1_req_ready_o, 1);
        tick();
        req_valid[1] = 1'b0;
        #2;
        chk("t3_next_p0", data_req_addr_o, 32'hA0A0_0000);
        tick();
        req_valid[0] = 1'b0;
        respond(2);

        // Fill the ID FIFO, then free one slot
        for (int i = 0; i < MAX_OUTST; i++) begin
            set_req(0, 1'b1, 32'h1000 + 32'(i * 4), 1'b0);
            tick();
        end
        set_req(0, 1'b1, 32'h2000, 1'b0);
        #2;
        chk("t4_full_valid",  data_req_valid_o, 0);
        chk("t4_full_ready0", m0_req_ready_o,   0);
        chk("t4_full_ready1", m1_req_ready_o,   0);
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'h5555_0000;
        #2;
        chk("t4_bubble_valid", data_req_valid_o, 0);
        tick();
        rsp_valid = 1'b0;
        #2;
        chk("t4_resume_valid", data_req_valid_o, 1);
        tick();
        req_valid[0] = 1'b0;
        respond(MAX_OUTST);

        // Outstanding IDs 1,0,1 answered with errors 0,1,0
        set_req(1, 1'b1, 32'h3100, 1'b0); tick(); req_valid[1] = 1'b0;
        set_req(0, 1'b1, 32'h3000, 1'b0); tick(); req_valid[0] = 1'b0;
        set_req(1, 1'b1, 32'h3104, 1'b0); tick(); req_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = 32'hC0DE_0000 + 32'(i);
            rsp_err   = (i == 1);
            #2;
            chk("t5_m0_valid", m0_rsp_valid_o, i == 1);
            chk("t5_m1_valid", m1_rsp_valid_o, i != 1);
            chk("t5_error", (i == 1) ? m0_rsp_error_o : m1_rsp_error_o, i == 1);
            tick();
        end
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;

        // Response with nothing outstanding
        rsp_valid = 1'b1;
        #2;
        chk("t6_spurious_hi", spurious_rsp_o, 1);
        tick();
        rsp_valid = 1'b0;
        #2;
        chk("t6_spurious_lo", spurious_rsp_o, 0);
        tick();

        // Asynchronous reset with two outstanding requests
        set_req(0, 1'b1, 32'h4000, 1'b0); tick();
        set_req(0, 1'b1, 32'h4004, 1'b0); tick();
        req_valid[0] = 1'b0;
        rsp_valid    = 1'b1;
        #2;
        chk("t6_pre_rst_rsp",  m0_rsp_valid_o, 1);
        chk("t6_pre_rst_spur", spurious_rsp_o, 0);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_spur",    spurious_rsp_o, 1);
        chk("t6_rst_m0_rsp",  m0_rsp_valid_o, 0);
        q.delete();
        lock = -1;
        rr   = 0;
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        tick();   // stale response after reset
        rsp_valid = 1'b0;

        // Randomized traffic honouring the hold-until-accepted rule
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++)
                if (!req_valid[p] || (last_fire && last_gnt == p))
                    set_req(p, $urandom_range(0, 99) < 60, $urandom, 1'($urandom));
            bus_ready = $urandom_range(0, 99) < 60;
            rsp_valid = $urandom_range(0, 99) < 40;
            rsp_data  = $urandom;
            rsp_err   = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_jedro_1_data_arbiter
